stream_unpacker: RTL and testbench

Parametrised width down-converter with a bit-accurate residual buffer. It replaces the integer-ratio unpacker for arbitrary IN_WIDTH/OUT_WIDTH ratios, including non-multiples such as 128->48. It uses full valid/ready handshakes on both sides and an end-of-stream flush with a zero-padded final word. It sits between the global-buffer read port and the PE-array feeders.

---
 rtl/stream_unpacker_if.sv | 28 ++
 rtl/stream_unpacker.sv | 70 +++++++
 tb/tb_stream_unpacker.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_unpacker_if.sv
// Handshake bundle for stream_unpacker: input word stream in, unpacked word stream out.
// slave is the unpacker's view; master is the producer/consumer pair driving it.
interface stream_unpacker_if #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 48
);
    localparam int NB_W = $clog2(OUT_WIDTH + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [NB_W-1:0]      out_nbits;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_nbits
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_nbits
    );
endinterface

// File: rtl/stream_unpacker.sv
// IN_WIDTH->OUT_WIDTH down-converter with bit-accurate residual buffer and zero-padded final word.
// Latency 1 cycle; in_ready depends only on held state, outputs hold stable while out_ready=0.
module stream_unpacker #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_unpacker_if.slave  bus
);
    localparam int BUF_W = IN_WIDTH + OUT_WIDTH - 1;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int NB_W  = $clog2(OUT_WIDTH + 1);
    localparam logic [CNT_W-1:0] OW_C = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0] IW_C = CNT_W'(IN_WIDTH);

    logic [BUF_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_pend_q, last_pend_d;

    logic             in_rdy;
    logic             out_vld;
    logic             out_lst;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] take;
    logic [CNT_W-1:0] r;

    always_comb begin
        in_rdy      = (cnt_q < OW_C) && !last_pend_q;
        out_vld     = (cnt_q >= OW_C) || (last_pend_q && (cnt_q != '0));
        out_lst     = last_pend_q && (cnt_q <= OW_C) && (cnt_q != '0);
        take        = (cnt_q < OW_C) ? cnt_q : OW_C;
        push        = bus.in_valid && in_rdy;
        pop         = out_vld && bus.out_ready;
        // New data lands at the post-pop offset so push and pop can share a cycle.
        r           = pop ? (cnt_q - take) : cnt_q;
        data_d      = pop ? (data_q >> OUT_WIDTH) : data_q;
        cnt_d       = r;
        last_pend_d = last_pend_q;
        if (push) begin
            data_d = data_d | (BUF_W'(bus.in_data) << r);
            cnt_d  = r + IW_C;
            if (bus.in_last) begin
                last_pend_d = 1'b1;
            end
        end
        if (pop && out_lst) begin
            last_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_last  = out_lst;
    assign bus.out_data  = data_q[OUT_WIDTH-1:0];
    assign bus.out_nbits = out_vld ? NB_W'(take) : '0;
endmodule

// File: tb/tb_stream_unpacker.sv
// Bench for stream_unpacker at 128->48, 128->64 and 32->32 against a bit-queue reference model.
module tb_stream_unpacker;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_unpacker_if #(.IN_WIDTH(128), .OUT_WIDTH(48)) b48 ();
    stream_unpacker_if #(.IN_WIDTH(128), .OUT_WIDTH(64)) b64 ();
    stream_unpacker_if #(.IN_WIDTH(32),  .OUT_WIDTH(32)) b32 ();

    stream_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(48)) u48 (.clk(clk), .rst_n(rst_n), .bus(b48));
    stream_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
    stream_unpacker #(.IN_WIDTH(32),  .OUT_WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    int           sel;
    logic         d_iv, d_il, d_ordy;
    logic [127:0] d_dat;

    assign b48.in_valid  = (sel == 0) && d_iv;
    assign b48.in_last   = d_il;
    assign b48.in_data   = d_dat;
    assign b48.out_ready = (sel == 0) && d_ordy;
    assign b64.in_valid  = (sel == 1) && d_iv;
    assign b64.in_last   = d_il;
    assign b64.in_data   = d_dat;
    assign b64.out_ready = (sel == 1) && d_ordy;
    assign b32.in_valid  = (sel == 2) && d_iv;
    assign b32.in_last   = d_il;
    assign b32.in_data   = d_dat[31:0];
    assign b32.out_ready = (sel == 2) && d_ordy;

    logic         o_ir, o_ov, o_ol;
    logic [127:0] o_od;
    int           o_nb;

    always_comb begin
        o_ir = 1'b0; o_ov = 1'b0; o_ol = 1'b0; o_od = '0; o_nb = 0;
        case (sel)
            0: begin o_ir = b48.in_ready; o_ov = b48.out_valid; o_ol = b48.out_last;
                     o_od = 128'(b48.out_data); o_nb = int'(b48.out_nbits); end
            1: begin o_ir = b64.in_ready; o_ov = b64.out_valid; o_ol = b64.out_last;
                     o_od = 128'(b64.out_data); o_nb = int'(b64.out_nbits); end
            default: begin o_ir = b32.in_ready; o_ov = b32.out_valid; o_ol = b32.out_last;
                     o_od = 128'(b32.out_data); o_nb = int'(b32.out_nbits); end
        endcase
    end

    // Reference model: bits held as a LSB-first queue plus a pending-end flag.
    bit           mq[$];
    bit           mlp;
    int           IW, OW;
    logic         e_ir, e_ov, e_ol;
    logic [127:0] e_od;
    int           e_nb;
    logic         s_ir, s_ov, s_ol;
    logic [127:0] s_od;
    int           s_nb;
    logic         pushed, popped;
    int           checks = 0;
    int           fails  = 0;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick(input logic iv, input logic [127:0] d, input logic il, input logic ordy);
        int n, k;
        n = mq.size();
        k = (n < OW) ? n : OW;
        e_ir = (n < OW) && !mlp;
        e_ov = (n >= OW) || (mlp && n != 0);
        e_ol = mlp && (n <= OW) && (n != 0);
        e_nb = e_ov ? k : 0;
        e_od = '0;
        for (int i = 0; i < k; i++) e_od[i] = mq[i];
        s_ir = o_ir; s_ov = o_ov; s_ol = o_ol; s_od = o_od; s_nb = o_nb;
        d_iv = iv; d_dat = d; d_il = il; d_ordy = ordy;
        pushed = iv && e_ir;
        popped = e_ov && ordy;
        if (popped) begin
            for (int i = 0; i < k; i++) void'(mq.pop_front());
            if (e_ol) mlp = 1'b0;
        end
        if (pushed) begin
            for (int i = 0; i < IW; i++) mq.push_back(d[i]);
            if (il) mlp = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int s, input int iw, input int ow);
        d_iv = 1'b0; d_ordy = 1'b0; d_il = 1'b0; d_dat = '0;
        rst_n = 1'b0;
        sel = s; IW = iw; OW = ow;
        mq.delete(); mlp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        d_iv = 1'b0; d_ordy = 1'b0; d_il = 1'b0; d_dat = '0;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++; if (o_ir !== 1'b1) begin fails++; $display("FAIL reset_in_ready dut%0d got=%b exp=1", s, o_ir); end
            checks++; if (o_ov !== 1'b0) begin fails++; $display("FAIL reset_out_valid dut%0d got=%b exp=0", s, o_ov); end
            checks++; if (o_ol !== 1'b0) begin fails++; $display("FAIL reset_out_last dut%0d got=%b exp=0", s, o_ol); end
            checks++; if (o_od !== '0)   begin fails++; $display("FAIL reset_out_data dut%0d got=%h exp=0", s, o_od); end
            checks++; if (o_nb !== 0)    begin fails++; $display("FAIL reset_out_nbits dut%0d got=%0d exp=0", s, o_nb); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ratio48_stream();
        logic [127:0] w[4];
        int idx = 0, pops = 0, last_nb = -1;
        bit done = 0;
        do_reset(0, 128, 48);
        for (int i = 0; i < 4; i++) w[i] = rnd128();
        for (int c = 0; c < 60 && !done; c++) begin
            tick(idx < 3, w[idx], idx == 2, 1'b1);
            checks++; if (s_ir !== e_ir) begin fails++; $display("FAIL r48_in_ready cyc%0d got=%b exp=%b", c, s_ir, e_ir); end
            checks++; if (s_ov !== e_ov) begin fails++; $display("FAIL r48_out_valid cyc%0d got=%b exp=%b", c, s_ov, e_ov); end
            checks++; if (s_ol !== e_ol) begin fails++; $display("FAIL r48_out_last cyc%0d got=%b exp=%b", c, s_ol, e_ol); end
            checks++; if (s_od !== e_od) begin fails++; $display("FAIL r48_out_data cyc%0d got=%h exp=%h", c, s_od, e_od); end
            checks++; if (s_nb !== e_nb) begin fails++; $display("FAIL r48_out_nbits cyc%0d got=%0d exp=%0d", c, s_nb, e_nb); end
            if (pushed) idx++;
            if (popped) begin pops++; if (s_ol) begin done = 1; last_nb = s_nb; end end
        end
        checks++; if (!done) begin fails++; $display("FAIL r48_timeout got=no_last exp=last_within_60"); end
        checks++; if (pops !== 8) begin fails++; $display("FAIL r48_word_count got=%0d exp=8", pops); end
        checks++; if (last_nb !== 48) begin fails++; $display("FAIL r48_last_nbits got=%0d exp=48", last_nb); end
    endtask

    task automatic test_flush_short();
        logic [127:0] w;
        int pops = 0, nb[3];
        logic [127:0] lastd = '0;
        bit done = 0;
        do_reset(0, 128, 48);
        w = rnd128();
        nb[0] = -1; nb[1] = -1; nb[2] = -1;
        for (int c = 0; c < 20 && !done; c++) begin
            tick(pops == 0 && mq.size() == 0 && !mlp, w, 1'b1, 1'b1);
            checks++; if (s_ir !== e_ir) begin fails++; $display("FAIL flush_in_ready cyc%0d got=%b exp=%b", c, s_ir, e_ir); end
            checks++; if (s_ov !== e_ov) begin fails++; $display("FAIL flush_out_valid cyc%0d got=%b exp=%b", c, s_ov, e_ov); end
            checks++; if (s_ol !== e_ol) begin fails++; $display("FAIL flush_out_last cyc%0d got=%b exp=%b", c, s_ol, e_ol); end
            checks++; if (s_od !== e_od) begin fails++; $display("FAIL flush_out_data cyc%0d got=%h exp=%h", c, s_od, e_od); end
            if (popped) begin
                if (pops < 3) nb[pops] = s_nb;
                pops++;
                if (s_ol) begin done = 1; lastd = s_od; end
            end
        end
        checks++; if (pops !== 3) begin fails++; $display("FAIL flush_word_count got=%0d exp=3", pops); end
        checks++; if (nb[0] !== 48) begin fails++; $display("FAIL flush_nbits0 got=%0d exp=48", nb[0]); end
        checks++; if (nb[2] !== 32) begin fails++; $display("FAIL flush_nbits2 got=%0d exp=32", nb[2]); end
        checks++; if (lastd !== {96'd0, w[127:96]}) begin fails++; $display("FAIL flush_pad got=%h exp=%h", lastd, {96'd0, w[127:96]}); end
        tick(1'b0, '0, 1'b0, 1'b1);
        checks++; if (s_ir !== 1'b1) begin fails++; $display("FAIL flush_ready_after got=%b exp=1", s_ir); end
    endtask

    task automatic test_ratio64_order();
        logic [127:0] w[5];
        logic [127:0] hw;
        int idx = 0, pops = 0, first = -1;
        do_reset(1, 128, 64);
        for (int i = 0; i < 5; i++) w[i] = rnd128();
        for (int c = 0; c < 40 && pops < 8; c++) begin
            tick(idx < 4, w[idx], 1'b0, 1'b1);
            checks++; if (s_ov !== e_ov) begin fails++; $display("FAIL r64_out_valid cyc%0d got=%b exp=%b", c, s_ov, e_ov); end
            checks++; if (s_ir !== e_ir) begin fails++; $display("FAIL r64_in_ready cyc%0d got=%b exp=%b", c, s_ir, e_ir); end
            if (c == first + 1 && first >= 0) begin
                checks++; if (s_ov !== 1'b1) begin fails++; $display("FAIL r64_latency got=%b exp=1", s_ov); end
            end
            if (pushed) begin if (first < 0) first = c; idx++; end
            if (popped) begin
                hw = w[pops / 2] >> (64 * (pops % 2));
                checks++; if (s_od[63:0] !== hw[63:0]) begin fails++; $display("FAIL r64_half%0d got=%h exp=%h", pops, s_od[63:0], hw[63:0]); end
                pops++;
            end
        end
        checks++; if (pops !== 8) begin fails++; $display("FAIL r64_word_count got=%0d exp=8", pops); end
    endtask

    task automatic test_random_traffic();
        int idx = 0;
        longint bits_out = 0;
        logic pv = 0, pr = 0, pl = 0;
        logic [127:0] pd = '0;
        bit done = 0;
        do_reset(0, 128, 48);
        for (int c = 0; c < 30000 && !done; c++) begin
            tick(idx < 1000 && $urandom_range(9) < 7, rnd128(), idx == 999 || $urandom_range(9) == 0, 1'($urandom_range(1)));
            checks++; if (s_ir !== e_ir) begin fails++; if (fails < 30) $display("FAIL rnd_in_ready cyc%0d got=%b exp=%b", c, s_ir, e_ir); end
            checks++; if (s_ov !== e_ov) begin fails++; if (fails < 30) $display("FAIL rnd_out_valid cyc%0d got=%b exp=%b", c, s_ov, e_ov); end
            checks++; if (s_ol !== e_ol) begin fails++; if (fails < 30) $display("FAIL rnd_out_last cyc%0d got=%b exp=%b", c, s_ol, e_ol); end
            checks++; if (s_od !== e_od) begin fails++; if (fails < 30) $display("FAIL rnd_out_data cyc%0d got=%h exp=%h", c, s_od, e_od); end
            checks++; if (s_nb !== e_nb) begin fails++; if (fails < 30) $display("FAIL rnd_out_nbits cyc%0d got=%0d exp=%0d", c, s_nb, e_nb); end
            if (pv && !pr) begin
                checks++; if (s_od !== pd || s_ol !== pl) begin fails++; if (fails < 30) $display("FAIL rnd_hold cyc%0d got=%h/%b exp=%h/%b", c, s_od, s_ol, pd, pl); end
            end
            checks++; if (u48.cnt_q > 8'd175) begin fails++; if (fails < 30) $display("FAIL rnd_cnt_bound got=%0d exp<=175", u48.cnt_q); end
            pv = s_ov; pr = d_ordy; pd = s_od; pl = s_ol;
            if (pushed) idx++;
            if (popped) bits_out += s_nb;
            done = (idx == 1000) && (mq.size() == 0) && !mlp;
        end
        checks++; if (!done) begin fails++; $display("FAIL rnd_timeout got=idx%0d exp=drained", idx); end
        checks++; if (bits_out !== 128000) begin fails++; $display("FAIL rnd_bit_total got=%0d exp=128000", bits_out); end
    endtask

    task automatic test_reset_mid();
        int pops = 0, last_nb = -1, idx = 0;
        logic [127:0] w[3];
        bit done = 0;
        do_reset(0, 128, 48);
        tick(1'b1, rnd128(), 1'b1, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1);
        checks++; if (u48.cnt_q !== 8'd80) begin fails++; $display("FAIL mid_setup_cnt got=%0d exp=80", u48.cnt_q); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_ov !== 1'b0) begin fails++; $display("FAIL mid_out_valid got=%b exp=0", o_ov); end
        checks++; if (o_ir !== 1'b1) begin fails++; $display("FAIL mid_in_ready got=%b exp=1", o_ir); end
        checks++; if (u48.cnt_q !== 8'd0) begin fails++; $display("FAIL mid_cnt got=%0d exp=0", u48.cnt_q); end
        mq.delete(); mlp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) w[i] = rnd128();
        for (int c = 0; c < 40 && !done; c++) begin
            tick(idx < 2, w[idx], idx == 1, 1'b1);
            checks++; if (s_od !== e_od) begin fails++; $display("FAIL mid_out_data cyc%0d got=%h exp=%h", c, s_od, e_od); end
            checks++; if (s_ol !== e_ol) begin fails++; $display("FAIL mid_out_last cyc%0d got=%b exp=%b", c, s_ol, e_ol); end
            if (pushed) idx++;
            if (popped) begin pops++; if (s_ol) begin done = 1; last_nb = s_nb; end end
        end
        checks++; if (pops !== 6) begin fails++; $display("FAIL mid_word_count got=%0d exp=6", pops); end
        checks++; if (last_nb !== 16) begin fails++; $display("FAIL mid_last_nbits got=%0d exp=16", last_nb); end
    endtask

    task automatic test_passthrough();
        logic [127:0] w;
        logic lq[$];
        logic exp_l;
        int idx = 0, pops = 0;
        bit done = 0;
        do_reset(2, 32, 32);
        for (int c = 0; c < 400 && !done; c++) begin
            w = rnd128();
            tick(idx < 20 && $urandom_range(9) < 8, w, idx == 19 || $urandom_range(3) == 0, 1'($urandom_range(1)));
            checks++; if (s_od !== e_od) begin fails++; $display("FAIL pass_out_data cyc%0d got=%h exp=%h", c, s_od, e_od); end
            checks++; if (s_ov !== e_ov) begin fails++; $display("FAIL pass_out_valid cyc%0d got=%b exp=%b", c, s_ov, e_ov); end
            if (popped) begin
                exp_l = lq.pop_front();
                checks++; if (s_ol !== exp_l) begin fails++; $display("FAIL pass_last%0d got=%b exp=%b", pops, s_ol, exp_l); end
                checks++; if (s_nb !== 32) begin fails++; $display("FAIL pass_nbits%0d got=%0d exp=32", pops, s_nb); end
                pops++;
            end
            if (pushed) begin lq.push_back(d_il); idx++; end
            done = (idx == 20) && (lq.size() == 0);
        end
        checks++; if (pops !== 20) begin fails++; $display("FAIL pass_word_count got=%0d exp=20", pops); end
    endtask

    initial begin
        sel = 0; IW = 128; OW = 48;
        d_iv = 1'b0; d_il = 1'b0; d_ordy = 1'b0; d_dat = '0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_ratio48_stream();
        test_flush_short();
        test_ratio64_order();
        test_random_traffic();
        test_reset_mid();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
